// File: rtl/direction_accumulator.sv
// direction_accumulator
// Sequential direction estimator for one frequency bin. Each peripheral
// microphone's phase is compared with the central microphone's phase. The
// difference is wrapped into [-pi, +pi] and weighted by that microphone's
// (x, y) location. A single multiply-accumulate lane processes one
// microphone per cycle. The sums are scaled down, saturated and presented
// with a valid/ready handshake.
//
// State table:
//   IDLE | ready_in high, waiting for an input bundle
//   CALC | one microphone per cycle: wrap difference, accumulate x/y
//   SAT  | shift and clamp accumulators, register result
//   OUT  | hold result with valid_out high until ready_out
//
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   valid_in / ready_in     input handshake (ready_in only in IDLE)
//   central_mic             {phase[H-1:0], magnitude[H-1:0]}
//   peripheral_mics         N samples, mic i at [i*DW +: DW]
//   mic_locations           N signed (x, y) pairs:
//                           x_i at [(2i)*H +: H], y_i at [(2i+1)*H +: H]
//   mag_threshold_in        confidence threshold on the central magnitude
//   valid_out / ready_out   output handshake
//   vector_out              {x[H-1:0], y[H-1:0]}, saturated
//   phase_differences_out   N wrapped differences, entry i at [i*(H+1) +: H+1]
//   confident_out           central magnitude >= threshold
module direction_accumulator #(
    parameter int                        PERIPHERAL_MICS = 3,
    parameter int                        DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH/2-1:0]   PI_Q            = 16'h6488,
    parameter int                        OUT_SHIFT       = 3
) (
    input  logic                                            clk_in,
    input  logic                                            rst_n_in,
    input  logic                                            valid_in,
    output logic                                            ready_in,
    input  logic [DATA_WIDTH-1:0]                           central_mic,
    input  logic [PERIPHERAL_MICS*DATA_WIDTH-1:0]           peripheral_mics,
    input  logic [2*PERIPHERAL_MICS*(DATA_WIDTH/2)-1:0]     mic_locations,
    input  logic [DATA_WIDTH/2-1:0]                         mag_threshold_in,
    output logic                                            valid_out,
    input  logic                                            ready_out,
    output logic [DATA_WIDTH-1:0]                           vector_out,
    output logic [PERIPHERAL_MICS*(DATA_WIDTH/2+1)-1:0]     phase_differences_out,
    output logic                                            confident_out
);

    localparam int N     = PERIPHERAL_MICS;
    localparam int H     = DATA_WIDTH / 2;
    localparam int PW    = H + 1;
    localparam int ACC_W = 2*H + 1 + $clog2(N + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [PW-1:0]    PI_P     = {1'b0, PI_Q};
    localparam logic signed [PW-1:0]    TWO_PI   = {PI_Q, 1'b0};
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-H+1){1'b0}}, {(H-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SAT  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [H-1:0]              r_c_phase;
    logic [H-1:0]              r_c_mag;
    logic [N*H-1:0]            r_p_phase;
    logic [H-1:0]              r_thresh;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc_x;
    logic signed [ACC_W-1:0]   r_acc_y;
    logic [DATA_WIDTH-1:0]     r_vector;
    logic [N*PW-1:0]           r_pd;
    logic                      r_conf;
    logic                      r_valid;

    logic [H-1:0]              w_p_phase;
    logic signed [H-1:0]       w_loc_x;
    logic signed [H-1:0]       w_loc_y;
    logic signed [PW-1:0]      w_diff_raw;
    logic signed [PW-1:0]      w_d;
    logic signed [ACC_W-1:0]   w_d_ext;
    logic signed [ACC_W-1:0]   w_prod_x;
    logic signed [ACC_W-1:0]   w_prod_y;
    logic signed [ACC_W-1:0]   w_sx;
    logic signed [ACC_W-1:0]   w_sy;
    logic                      w_last;

    function automatic logic [H-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX)
            c = SAT_MAX;
        else if (v < SAT_MIN)
            c = SAT_MIN;
        else
            c = v;
        return c[H-1:0];
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    assign w_last = (r_idx == IDX_W'(N - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (valid_in) w_next_state = S_CALC;
            S_CALC: if (w_last)   w_next_state = S_SAT;
            S_SAT:                w_next_state = S_OUT;
            S_OUT:  if (ready_out) w_next_state = S_IDLE;
            default:              w_next_state = S_IDLE;
        endcase
    end

    // Select the current microphone's captured phase and live location.
    always_comb begin
        w_p_phase = '0;
        w_loc_x   = '0;
        w_loc_y   = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_p_phase = r_p_phase[i*H +: H];
                w_loc_x   = mic_locations[(2*i)*H +: H];
                w_loc_y   = mic_locations[(2*i+1)*H +: H];
            end
        end
    end

    // One extra bit holds any difference of two H-bit phases; a single
    // wrap brings it back inside [-pi, +pi], with exactly +/-pi left alone.
    always_comb begin
        w_diff_raw = $signed({w_p_phase[H-1], w_p_phase}) - $signed({r_c_phase[H-1], r_c_phase});
        if (w_diff_raw > PI_P)
            w_d = w_diff_raw - TWO_PI;
        else if (w_diff_raw < -PI_P)
            w_d = w_diff_raw + TWO_PI;
        else
            w_d = w_diff_raw;
    end

    assign w_d_ext  = ACC_W'(w_d);
    assign w_prod_x = w_d_ext * ACC_W'(w_loc_x);
    assign w_prod_y = w_d_ext * ACC_W'(w_loc_y);
    assign w_sx     = r_acc_x >>> OUT_SHIFT;
    assign w_sy     = r_acc_y >>> OUT_SHIFT;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_c_phase <= '0;
            r_c_mag   <= '0;
            r_p_phase <= '0;
            r_thresh  <= '0;
            r_idx     <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_vector  <= '0;
            r_pd      <= '0;
            r_conf    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_c_phase <= central_mic[DATA_WIDTH-1:H];
                        r_c_mag   <= central_mic[H-1:0];
                        for (int i = 0; i < N; i++)
                            r_p_phase[i*H +: H] <= peripheral_mics[i*DATA_WIDTH + H +: H];
                        r_thresh  <= mag_threshold_in;
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_idx     <= '0;
                    end
                end
                S_CALC: begin
                    for (int i = 0; i < N; i++)
                        if (r_idx == IDX_W'(i))
                            r_pd[i*PW +: PW] <= w_d;
                    r_acc_x <= r_acc_x + w_prod_x;
                    r_acc_y <= r_acc_y + w_prod_y;
                    r_idx   <= r_idx + 1'b1;
                end
                S_SAT: begin
                    r_vector <= {clamp(w_sx), clamp(w_sy)};
                    r_conf   <= (r_c_mag >= r_thresh);
                    r_valid  <= 1'b1;
                end
                S_OUT: begin
                    if (ready_out)
                        r_valid <= 1'b0;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign ready_in              = (r_state == S_IDLE);
    assign valid_out             = r_valid;
    assign vector_out            = r_vector;
    assign phase_differences_out = r_pd;
    assign confident_out         = r_conf;

endmodule
